// File: rtl/voice_allocator_if.sv
// Sequencer-to-allocator note handshake plus the per-player strobe/slot bus.
// The sequencer (master) drives note_valid/note_in/duration_in/flush/note_done; the allocator (slave) drives the rest.
interface voice_allocator_if #(
  parameter int NUM_VOICES = 3,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Handshake: an entry transfers on a rising clk edge where note_valid && note_ready && !flush.
  logic                    note_valid;
  logic [5:0]              note_in;
  logic [5:0]              duration_in;
  logic                    note_ready;
  logic                    flush;
  logic [NUM_VOICES-1:0]   note_done;
  logic [NUM_VOICES-1:0]   new_note;
  logic [6*NUM_VOICES-1:0] voice_note;
  logic [6*NUM_VOICES-1:0] voice_duration;
  logic [NUM_VOICES-1:0]   voice_busy;
  logic [CNT_W-1:0]        pending;
  logic                    idle;

  modport master (
    output note_valid, note_in, duration_in, flush, note_done,
    input  note_ready, new_note, voice_note, voice_duration, voice_busy, pending, idle
  );

  modport slave (
    input  note_valid, note_in, duration_in, flush, note_done,
    output note_ready, new_note, voice_note, voice_duration, voice_busy, pending, idle
  );
endinterface

// File: rtl/voice_allocator.sv
// Pending-note FIFO feeding a pool of note players, lowest-index free voice first.
// Rests are popped without touching any voice; a blocked head note stalls the queue in order.
module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int DEPTH      = 4
) (
  input  logic             clk,
  input  logic             reset,
  voice_allocator_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int VW    = 6 * NUM_VOICES;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [11:0]           r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [NUM_VOICES-1:0] r_busy;
  logic [NUM_VOICES-1:0] r_new_note;
  logic [VW-1:0]         r_voice_note;
  logic [VW-1:0]         r_voice_dur;

  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_dispatch;
  logic [11:0]           w_head;
  logic [NUM_VOICES-1:0] w_sel_oh;
  logic                  w_any_free;

  // Priority pick: the first free voice from index 0 upward wins.
  always_comb begin
    w_sel_oh   = '0;
    w_any_free = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!r_busy[i] && !w_any_free) begin
        w_sel_oh[i] = 1'b1;
        w_any_free  = 1'b1;
      end
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign w_ready    = (r_count != FULL);
  assign w_push     = bus.note_valid & w_ready & ~bus.flush;
  assign w_pop      = (r_count != '0) & ~bus.flush & ((w_head[11:6] == 6'd0) | w_any_free);
  assign w_dispatch = w_pop & (w_head[11:6] != 6'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {bus.note_in, bus.duration_in};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // A voice cleared by note_done this edge is not yet visible to the picker, so set/clear never overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy       <= '0;
      r_new_note   <= '0;
      r_voice_note <= '0;
      r_voice_dur  <= '0;
    end else begin
      r_busy     <= (r_busy & ~bus.note_done) | (w_dispatch ? w_sel_oh : '0);
      r_new_note <= w_dispatch ? w_sel_oh : '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (w_dispatch && w_sel_oh[i]) begin
          r_voice_note[6*i +: 6] <= w_head[11:6];
          r_voice_dur[6*i +: 6]  <= w_head[5:0];
        end
      end
    end
  end

  assign bus.note_ready     = w_ready;
  assign bus.new_note       = r_new_note;
  assign bus.voice_note     = r_voice_note;
  assign bus.voice_duration = r_voice_dur;
  assign bus.voice_busy     = r_busy;
  assign bus.pending        = r_count;
  assign bus.idle           = (r_count == '0) && (r_busy == '0);
endmodule

// File: tb/tb_voice_allocator.sv
// Directed and random stimulus for voice_allocator, checked against a queue/array model of the allocation rules.
module tb_voice_allocator;
  localparam int NV    = 3;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  voice_allocator_if #(.NUM_VOICES(NV), .DEPTH(DEPTH)) bus ();

  voice_allocator #(.NUM_VOICES(NV), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending queue of {note,duration}, busy flags, slot contents
  logic [11:0]      mq[$];
  logic [NV-1:0]    m_busy;
  logic [NV-1:0]    m_new;
  logic [6*NV-1:0]  m_vn;
  logic [6*NV-1:0]  m_vd;

  task automatic model_reset();
    mq.delete();
    m_busy = '0;
    m_new  = '0;
    m_vn   = '0;
    m_vd   = '0;
  endtask

  task automatic model_edge(input bit v, input logic [5:0] n, input logic [5:0] d,
                            input bit f, input logic [NV-1:0] done);
    logic [11:0]   head;
    logic [NV-1:0] pick;
    bit            accept;
    accept = v && (mq.size() != DEPTH) && !f;
    pick   = '0;
    if (!f && mq.size() > 0) begin
      head = mq[0];
      if (head[11:6] == 6'd0) begin
        void'(mq.pop_front());
      end else begin
        for (int i = 0; i < NV; i++)
          if (!m_busy[i] && pick == '0) pick[i] = 1'b1;
        if (pick != '0) begin
          void'(mq.pop_front());
          for (int i = 0; i < NV; i++)
            if (pick[i]) begin
              m_vn[6*i +: 6] = head[11:6];
              m_vd[6*i +: 6] = head[5:0];
            end
        end
      end
    end
    m_busy = (m_busy & ~done) | pick;
    m_new  = pick;
    if (f) mq.delete();
    else if (accept) mq.push_back({n, d});
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("new_note",       32'(bus.new_note),       32'(m_new));
    check("voice_note",     32'(bus.voice_note),     32'(m_vn));
    check("voice_duration", 32'(bus.voice_duration), 32'(m_vd));
    check("voice_busy",     32'(bus.voice_busy),     32'(m_busy));
    check("pending",        32'(bus.pending),        32'(mq.size()));
    check("note_ready",     32'(bus.note_ready),     32'(mq.size() != DEPTH));
    check("idle",           32'(bus.idle),           32'(mq.size() == 0 && m_busy == '0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_new_note"}, 32'(bus.new_note),       32'd0);
    check({tag, "_vnote"},    32'(bus.voice_note),     32'd0);
    check({tag, "_vdur"},     32'(bus.voice_duration), 32'd0);
    check({tag, "_busy"},     32'(bus.voice_busy),     32'd0);
    check({tag, "_pending"},  32'(bus.pending),        32'd0);
    check({tag, "_ready"},    32'(bus.note_ready),     32'd1);
    check({tag, "_idle"},     32'(bus.idle),           32'd1);
  endtask

  // Driver: inputs change at negedge, model advances at posedge, outputs sampled 1 time unit later
  task automatic step(input bit v, input logic [5:0] n, input logic [5:0] d,
                      input bit f, input logic [NV-1:0] done);
    @(negedge clk);
    bus.note_valid  = v;
    bus.note_in     = n;
    bus.duration_in = d;
    bus.flush       = f;
    bus.note_done   = done;
    @(posedge clk);
    model_edge(v, n, d, f, done);
    #1;
    check_model();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && !(mq.size() == 0 && m_busy == '0); k++)
      step(1'b0, 6'd0, 6'd0, 1'b0, '1);
    check("drain_idle", 32'(bus.idle), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.note_valid  = 1'b0;
    bus.note_in     = '0;
    bus.duration_in = '0;
    bus.flush       = 1'b0;
    bus.note_done   = '0;
    reset = 1'b0;
    model_reset();
    #12;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;

    // Basic dispatch
    step(1'b1, 6'd12, 6'd4, 1'b0, '0);
    step(1'b0, 6'd0, 6'd0, 1'b0, '0);
    check("basic_strobe", 32'(bus.new_note), 32'h1);
    check("basic_note",   32'(bus.voice_note[5:0]), 32'd12);
    check("basic_dur",    32'(bus.voice_duration[5:0]), 32'd4);
    check("basic_busy",   32'(bus.voice_busy), 32'h1);
    check("basic_idle",   32'(bus.idle), 32'd0);
    drain();

    // Fill order and blocking head
    step(1'b1, 6'd5, 6'd1, 1'b0, '0);
    step(1'b1, 6'd6, 6'd2, 1'b0, '0);
    step(1'b1, 6'd7, 6'd3, 1'b0, '0);
    step(1'b1, 6'd8, 6'd4, 1'b0, '0);
    step(1'b0, 6'd0, 6'd0, 1'b0, '0);
    check("fill_pending", 32'(bus.pending), 32'd1);
    check("fill_busy",    32'(bus.voice_busy), 32'h7);
    check("fill_slots",   32'(bus.voice_note), {14'd0, 6'd7, 6'd6, 6'd5});
    step(1'b0, 6'd0, 6'd0, 1'b0, 3'b010);
    check("fill_no_same_cycle", 32'(bus.new_note), 32'h0);
    step(1'b0, 6'd0, 6'd0, 1'b0, '0);
    check("fill_reuse_strobe", 32'(bus.new_note), 32'h2);
    check("fill_reuse_note",   32'(bus.voice_note[11:6]), 32'd8);

    // Full FIFO with every voice busy
    for (int k = 0; k < 4; k++) step(1'b1, 6'(30 + k), 6'(k + 1), 1'b0, '0);
    check("full_pending", 32'(bus.pending), 32'd4);
    check("full_ready",   32'(bus.note_ready), 32'd0);
    for (int k = 0; k < 3; k++) step(1'b1, 6'd40, 6'd9, 1'b0, '0);
    check("full_held", 32'(bus.pending), 32'd4);
    step(1'b1, 6'd40, 6'd9, 1'b0, 3'b001);
    step(1'b1, 6'd40, 6'd9, 1'b0, '0);
    check("full_pop_refused", 32'(bus.pending), 32'd3);
    check("full_ready_back",  32'(bus.note_ready), 32'd1);
    check("full_strobe",      32'(bus.new_note), 32'h1);
    drain();

    // Rests
    step(1'b1, 6'd0, 6'd8, 1'b0, '0);
    step(1'b1, 6'd20, 6'd2, 1'b0, '0);
    check("rest_no_strobe", 32'(bus.new_note), 32'h0);
    check("rest_no_busy",   32'(bus.voice_busy), 32'h0);
    step(1'b0, 6'd0, 6'd0, 1'b0, '0);
    check("rest_next_strobe", 32'(bus.new_note), 32'h1);
    check("rest_next_note",   32'(bus.voice_note[5:0]), 32'd20);
    drain();

    // Flush with a simultaneous offer
    for (int k = 0; k < 6; k++) step(1'b1, 6'(50 + k), 6'd5, 1'b0, '0);
    check("flush_pre_pending", 32'(bus.pending), 32'd3);
    step(1'b1, 6'd33, 6'd3, 1'b1, '0);
    check("flush_pending", 32'(bus.pending), 32'd0);
    check("flush_busy",    32'(bus.voice_busy), 32'h7);
    step(1'b0, 6'd0, 6'd0, 1'b0, '0);
    check("flush_dropped", 32'(bus.new_note), 32'h0);
    drain();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [5:0]    n;
      logic [NV-1:0] dn;
      n  = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      dn = ($urandom_range(0, 2) == 0) ? NV'($urandom_range(0, 7)) : '0;
      step(1'($urandom_range(0, 1)), n, 6'($urandom_range(0, 63)),
           ($urandom_range(0, 19) == 0), dn);
    end
    drain();

    // Asynchronous reset between edges
    for (int k = 0; k < 5; k++) step(1'b1, 6'(10 + k), 6'd7, 1'b0, '0);
    check("areset_pre_pending", 32'(bus.pending), 32'd2);
    check("areset_pre_busy",    32'(bus.voice_busy), 32'h7);
    bus.note_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_state("areset");
    @(posedge clk);
    #1;
    check("areset_hold_strobe", 32'(bus.new_note), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("release");
    step(1'b1, 6'd44, 6'd6, 1'b0, '0);
    step(1'b0, 6'd0, 6'd0, 1'b0, '0);
    check("post_reset_strobe", 32'(bus.new_note), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
